imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction RAM between the core fetch port and a program loader
//  (debug/boot host). Also sequences boot: holds the core in reset while the loader fills
//  memory, then releases it. Sits between the core, the loader and the instruction RAM wrap.
// PARAMETERS
//  ADDR_W     12  word-address width of instruction RAM
//  DATA_W     32  data width
//  STARVE_LIM 8   consecutive cycles a RUN-state loader request may wait before forced grant
// PORTS
//  clk           in   1       system clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  fetch_req_i   in   1       core fetch request
//  fetch_addr_i  in   ADDR_W  core fetch word address
//  fetch_gnt_o   out  1       fetch accepted this cycle
//  fetch_rvalid_o out 1       fetch data valid (1 cycle after grant)
//  ld_req_i      in   1       loader request
//  ld_we_i       in   1       loader write enable
//  ld_addr_i     in   ADDR_W  loader word address
//  ld_wdata_i    in   DATA_W  loader write data
//  ld_gnt_o      out  1       loader request accepted this cycle
//  ld_rvalid_o   out  1       loader read data / write ack valid (1 cycle after grant)
//  ld_done_i     in   1       pulse: program load complete, start core
//  ld_halt_i     in   1       pulse: stop core and return to BOOT
//  rdata_o       out  DATA_W  RAM read data, shared by both rvalid outputs
//  core_rst_n_o  out  1       reset to core, low = held in reset
//  mem_req_o     out  1       RAM enable
//  mem_we_o      out  1       RAM write enable
//  mem_addr_o    out  ADDR_W  RAM address
//  mem_wdata_o   out  DATA_W  RAM write data
//  mem_rdata_i   in   DATA_W  RAM read data, valid 1 cycle after mem_req_o
// BEHAVIOUR
//  Reset: state=BOOT, core_rst_n_o=0, all gnt/rvalid/mem_req_o/mem_we_o=0, starve_cnt=0.
//  Grants are combinational from req and state; exactly one owner per cycle, never both.
//  FSM:
//   BOOT : loader sole owner; ld_gnt_o=ld_req_i; fetch_gnt_o=0. ld_done_i -> RUN.
//   RUN  : core_rst_n_o=1. Fetch has priority. Loader granted when fetch_req_i=0, or when
//          starve_cnt==STARVE_LIM (forced grant: fetch_gnt_o=0 that cycle). Loader writes in RUN
//          are legal (self-modifying/patch). ld_halt_i -> DRAIN. ld_done_i ignored.
//   DRAIN: no new grants; wait until no read outstanding, then core_rst_n_o=0 and -> BOOT.
//          If nothing outstanding on entry, DRAIN lasts exactly 1 cycle.
//  starve_cnt: increments each RUN cycle with ld_req_i=1 and ld_gnt_o=0; clears on ld_gnt_o or
//   ld_req_i=0 or leaving RUN; saturates at STARVE_LIM.
//  Latency: rvalid to the granted owner exactly 1 cycle after grant (reads and writes);
//   owner tag registered at grant. rdata_o = mem_rdata_i (undefined on write acks).
//  mem_* = granted requester's fields; mem_we_o only with ld_gnt_o & ld_we_i.
//  Simultaneous ld_done_i and ld_halt_i: halt wins (RUN->DRAIN; in BOOT, stay in BOOT).
//  Reset mid-transaction: pending rvalid dropped, core back in reset, BOOT.
//  core_rst_n_o is registered (glitch-free) and changes only on state transitions.
// STRUCTURE
//  Shared package imem_pkg: state encoding (BOOT=2'd0, RUN=2'd1, DRAIN=2'd2), owner tag
//  constants OWN_FETCH/OWN_LD, ADDR_W/DATA_W defaults.
//  One sub-module: imem_starve_cnt (saturating counter with clear/enable, width $clog2(STARVE_LIM+1)).
//  Arbitration, owner tag and FSM are kept in imem_arbiter.
// TESTING
//  1 Reset, loader writes 0x00000013 @0..3 in BOOT -> 4 ld_gnt_o, mem_we_o=1, fetch_gnt_o=0, core_rst_n_o=0.
//  2 ld_done_i pulse -> core_rst_n_o=1 next cycle; fetch @0 -> fetch_rvalid_o=1, rdata_o=0x00000013 after 1 cycle.
//  3 RUN, fetch_req_i held 1, loader read @2 -> ld_gnt_o on the 9th waiting cycle (STARVE_LIM=8), rvalid next cycle.
//  4 Fetch and loader request in same cycle with starve_cnt=0 -> fetch granted, loader waits, starve_cnt=1.
//  5 ld_halt_i with fetch read outstanding -> rvalid still delivered, then core_rst_n_o=0, state BOOT.
//  6 rst_n low mid-RUN with grant pending -> all outputs at reset values immediately, no stray rvalid.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-RAM arbiter and boot sequencer.
package imem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef logic owner_t;
    localparam owner_t OWN_FETCH = 1'b0;
    localparam owner_t OWN_LD    = 1'b1;

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating wait counter for a starved loader request; clear has priority over enable.
module imem_starve_cnt #(
    parameter int LIM = 8,
    parameter int W   = $clog2(LIM + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic sat_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != W'(LIM))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == W'(LIM));

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction RAM arbiter between core fetch and program loader, plus boot sequencing.
//   state | meaning
//   BOOT  | core held in reset, loader sole owner of the RAM
//   RUN   | core running, fetch has priority, loader gets forced grant after starving
//   DRAIN | no new grants, wait for the last response, then back to BOOT
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    input  logic              ld_req_i,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_gnt_o,
    output logic              ld_rvalid_o,
    input  logic              ld_done_i,
    input  logic              ld_halt_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              core_rst_n_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e state_q, state_d;
    logic   core_rst_n_q, core_rst_n_d;
    logic   rv_valid_q, rv_valid_d;
    owner_t owner_q, owner_d;
    logic   starve_en;
    logic   starve_sat;

    imem_starve_cnt #(.LIM(STARVE_LIM)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!starve_en),
        .en_i  (starve_en),
        .sat_o (starve_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            core_rst_n_q <= 1'b0;
            rv_valid_q   <= 1'b0;
            owner_q      <= OWN_FETCH;
        end else begin
            state_q      <= state_d;
            core_rst_n_q <= core_rst_n_d;
            rv_valid_q   <= rv_valid_d;
            owner_q      <= owner_d;
        end
    end

    // Halt beats done in both BOOT and RUN; DRAIN leaves once no response is pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  if (ld_done_i && !ld_halt_i) state_d = ST_RUN;
            ST_RUN:   if (ld_halt_i) state_d = ST_DRAIN;
            ST_DRAIN: if (!rv_valid_q) state_d = ST_BOOT;
            default:  state_d = ST_BOOT;
        endcase
        core_rst_n_d = (state_d != ST_BOOT);
    end

    // Grants are gated by rst_n so nothing is accepted while reset is asserted.
    always_comb begin
        fetch_gnt_o = 1'b0;
        ld_gnt_o    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_BOOT: ld_gnt_o = ld_req_i;
                ST_RUN: begin
                    fetch_gnt_o = fetch_req_i && !(ld_req_i && starve_sat);
                    ld_gnt_o    = ld_req_i && (!fetch_req_i || starve_sat);
                end
                default: ;
            endcase
        end
        starve_en  = (state_q == ST_RUN) && ld_req_i && !ld_gnt_o;
        rv_valid_d = fetch_gnt_o || ld_gnt_o;
        owner_d    = ld_gnt_o ? OWN_LD : OWN_FETCH;
    end

    assign fetch_rvalid_o = rv_valid_q && (owner_q == OWN_FETCH);
    assign ld_rvalid_o    = rv_valid_q && (owner_q == OWN_LD);
    assign rdata_o        = mem_rdata_i;
    assign core_rst_n_o   = core_rst_n_q;
    assign mem_req_o      = fetch_gnt_o || ld_gnt_o;
    assign mem_we_o       = ld_gnt_o && ld_we_i;
    assign mem_addr_o     = ld_gnt_o ? ld_addr_i : fetch_addr_i;
    assign mem_wdata_o    = ld_wdata_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed boot/run/halt/reset scenarios plus randomized RUN traffic.
module tb_imem_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int LIM = 8;

    logic          clk, rst_n;
    logic          fetch_req, fetch_gnt, fetch_rvalid;
    logic [AW-1:0] fetch_addr;
    logic          ld_req, ld_we, ld_gnt, ld_rvalid, ld_done, ld_halt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata, rdata;
    logic          core_rst_n, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int vectors = 0;
    int errors  = 0;

    imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
        .fetch_gnt_o(fetch_gnt), .fetch_rvalid_o(fetch_rvalid),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid),
        .ld_done_i(ld_done), .ld_halt_i(ld_halt),
        .rdata_o(rdata), .core_rst_n_o(core_rst_n),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one cycle read latency
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        fetch_req = 0; ld_req = 0; ld_we = 0; ld_done = 0; ld_halt = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; fetch_req = 1; ld_req = 1; ld_we = 1; ld_addr = 0; fetch_addr = 0;
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL reset_fetch_gnt: got %b expected 0", fetch_gnt); end
        vectors++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL reset_ld_gnt: got %b expected 0", ld_gnt); end
        vectors++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n: got %b expected 0", core_rst_n); end
        vectors++; if ({mem_req, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem: got req/we %b expected 00", {mem_req, mem_we}); end
        vectors++; if ({fetch_rvalid, ld_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {fetch_rvalid, ld_rvalid}); end
        tick();
        idle_inputs();
        rst_n = 1;
        tick();
    endtask

    task automatic test_boot_load;
        for (int i = 0; i < 4; i++) begin
            fetch_req = 1; fetch_addr = AW'(i + 8);
            ld_req = 1; ld_we = 1; ld_addr = AW'(i); ld_wdata = 32'h0000_0013;
            @(negedge clk);
            vectors++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL boot_ld_gnt[%0d]: got %b expected 1", i, ld_gnt); end
            vectors++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL boot_fetch_gnt[%0d]: got %b expected 0", i, fetch_gnt); end
            vectors++; if (mem_we !== 1'b1) begin errors++; $display("FAIL boot_mem_we[%0d]: got %b expected 1", i, mem_we); end
            vectors++; if (mem_addr !== AW'(i)) begin errors++; $display("FAIL boot_mem_addr[%0d]: got %0h expected %0h", i, mem_addr, i); end
            vectors++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL boot_core_rst_n[%0d]: got %b expected 0", i, core_rst_n); end
            ref_mem[i] = 32'h0000_0013;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        vectors++; if (ld_rvalid !== 1'b1) begin errors++; $display("FAIL boot_write_ack: got %b expected 1", ld_rvalid); end
        tick();
    endtask

    task automatic test_done_fetch;
        ld_done = 1;
        @(negedge clk);
        vectors++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL done_before_edge: got %b expected 0", core_rst_n); end
        tick();
        ld_done = 0;
        fetch_req = 1; fetch_addr = 0;
        @(negedge clk);
        vectors++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL done_core_rst_n: got %b expected 1", core_rst_n); end
        vectors++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL run_fetch_gnt: got %b expected 1", fetch_gnt); end
        tick();
        fetch_req = 0;
        @(negedge clk);
        vectors++; if (fetch_rvalid !== 1'b1) begin errors++; $display("FAIL run_fetch_rvalid: got %b expected 1", fetch_rvalid); end
        vectors++; if (rdata !== 32'h0000_0013) begin errors++; $display("FAIL run_fetch_rdata: got %h expected 00000013", rdata); end
        tick();
    endtask

    task automatic test_starve;
        int gnt_k = 0;
        fetch_req = 1; fetch_addr = 5;
        ld_req = 1; ld_we = 0; ld_addr = 2;
        for (int k = 1; k <= 20 && gnt_k == 0; k++) begin
            @(negedge clk);
            if (ld_gnt === 1'b1) begin
                gnt_k = k;
                vectors++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL starve_forced_fetch_gnt: got %b expected 0", fetch_gnt); end
            end else begin
                vectors++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL starve_wait_fetch_gnt[%0d]: got %b expected 1", k, fetch_gnt); end
            end
            tick();
        end
        vectors++; if (gnt_k != LIM + 1) begin errors++; $display("FAIL starve_grant_cycle: got %0d expected %0d", gnt_k, LIM + 1); end
        idle_inputs();
        @(negedge clk);
        vectors++; if (ld_rvalid !== 1'b1) begin errors++; $display("FAIL starve_ld_rvalid: got %b expected 1", ld_rvalid); end
        vectors++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL starve_fetch_rvalid: got %b expected 0", fetch_rvalid); end
        vectors++; if (rdata !== ref_mem[2]) begin errors++; $display("FAIL starve_rdata: got %h expected %h", rdata, ref_mem[2]); end
        tick();
    endtask

    task automatic test_random_run;
        int waited = 0;
        bit pfg = 0, plg = 0, prd = 0, efg, elg;
        logic [DW-1:0] pdata = '0;
        for (int n = 0; n < 400; n++) begin
            fetch_req  = ($urandom_range(0, 9) < 8);
            fetch_addr = AW'($urandom_range(0, 15));
            ld_req     = ($urandom_range(0, 9) < 7);
            ld_we      = 1'($urandom_range(0, 1));
            ld_addr    = AW'($urandom_range(0, 15));
            ld_wdata   = $urandom;
            efg = fetch_req && !(ld_req && waited == LIM);
            elg = ld_req && (!fetch_req || waited == LIM);
            @(negedge clk);
            vectors++; if (fetch_gnt !== efg) begin errors++; $display("FAIL rnd_fetch_gnt[%0d]: got %b expected %b", n, fetch_gnt, efg); end
            vectors++; if (ld_gnt !== elg) begin errors++; $display("FAIL rnd_ld_gnt[%0d]: got %b expected %b", n, ld_gnt, elg); end
            vectors++; if (mem_we !== (elg && ld_we)) begin errors++; $display("FAIL rnd_mem_we[%0d]: got %b expected %b", n, mem_we, elg && ld_we); end
            vectors++; if (mem_req !== (efg || elg)) begin errors++; $display("FAIL rnd_mem_req[%0d]: got %b expected %b", n, mem_req, efg || elg); end
            if (elg) begin
                vectors++; if (mem_addr !== ld_addr) begin errors++; $display("FAIL rnd_mem_addr_ld[%0d]: got %h expected %h", n, mem_addr, ld_addr); end
            end else if (efg) begin
                vectors++; if (mem_addr !== fetch_addr) begin errors++; $display("FAIL rnd_mem_addr_fetch[%0d]: got %h expected %h", n, mem_addr, fetch_addr); end
            end
            vectors++; if (fetch_rvalid !== pfg) begin errors++; $display("FAIL rnd_fetch_rvalid[%0d]: got %b expected %b", n, fetch_rvalid, pfg); end
            vectors++; if (ld_rvalid !== plg) begin errors++; $display("FAIL rnd_ld_rvalid[%0d]: got %b expected %b", n, ld_rvalid, plg); end
            if ((pfg || plg) && prd) begin
                vectors++; if (rdata !== pdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", n, rdata, pdata); end
            end
            pfg   = efg;
            plg   = elg;
            prd   = efg || (elg && !ld_we);
            pdata = efg ? ref_mem[fetch_addr] : ref_mem[ld_addr];
            if (elg && ld_we) ref_mem[ld_addr] = ld_wdata;
            waited = (ld_req && !elg) ? ((waited < LIM) ? waited + 1 : LIM) : 0;
            tick();
        end
        idle_inputs();
        @(negedge clk);
        vectors++; if ({fetch_rvalid, ld_rvalid} !== {pfg, plg}) begin errors++; $display("FAIL rnd_last_rvalid: got %b expected %b", {fetch_rvalid, ld_rvalid}, {pfg, plg}); end
        tick();
    endtask

    task automatic test_halt_drain;
        logic [DW-1:0] exp_d;
        int seen = 0;
        fetch_req = 1; fetch_addr = 1; ld_halt = 1;
        exp_d = ref_mem[1];
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL halt_fetch_gnt: got %b expected 1", fetch_gnt); end
        tick();
        ld_halt = 0; fetch_req = 1;
        @(negedge clk);
        vectors++; if (fetch_rvalid !== 1'b1) begin errors++; $display("FAIL drain_rvalid: got %b expected 1", fetch_rvalid); end
        vectors++; if (rdata !== exp_d) begin errors++; $display("FAIL drain_rdata: got %h expected %h", rdata, exp_d); end
        vectors++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL drain_no_gnt: got %b expected 0", fetch_gnt); end
        vectors++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL drain_core_rst_n: got %b expected 1", core_rst_n); end
        for (int k = 0; k < 6 && seen == 0; k++) begin
            tick();
            @(negedge clk);
            vectors++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL drain_wait_gnt[%0d]: got %b expected 0", k, fetch_gnt); end
            if (core_rst_n === 1'b0) seen = 1;
        end
        vectors++; if (seen != 1) begin errors++; $display("FAIL drain_timeout: got core_rst_n %b expected 0", core_rst_n); end
        fetch_req = 1; ld_req = 1; ld_we = 0; ld_addr = 1;
        @(negedge clk);
        vectors++; if ({ld_gnt, fetch_gnt} !== 2'b10) begin errors++; $display("FAIL back_in_boot_gnt: got %b expected 10", {ld_gnt, fetch_gnt}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_done_halt_priority;
        ld_done = 1; ld_halt = 1;
        tick();
        ld_done = 0; ld_halt = 0; fetch_req = 1; fetch_addr = 0;
        @(negedge clk);
        vectors++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL boot_halt_wins: got %b expected 0", core_rst_n); end
        vectors++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL boot_halt_fetch: got %b expected 0", fetch_gnt); end
        tick();
        fetch_req = 0; ld_done = 1;
        tick();
        fetch_req = 1;
        @(negedge clk);
        vectors++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL rerun_core_rst_n: got %b expected 1", core_rst_n); end
        vectors++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL run_done_ignored: got %b expected 1", fetch_gnt); end
        tick();
        fetch_req = 0; ld_done = 1; ld_halt = 1;
        tick();
        ld_done = 0; ld_halt = 0; fetch_req = 1;
        @(negedge clk);
        vectors++; if ({core_rst_n, fetch_gnt} !== 2'b10) begin errors++; $display("FAIL run_halt_wins: got %b expected 10", {core_rst_n, fetch_gnt}); end
        tick();
        @(negedge clk);
        vectors++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL drain_one_cycle: got %b expected 0", core_rst_n); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        ld_done = 1;
        tick();
        ld_done = 0; fetch_req = 1; fetch_addr = 2;
        @(negedge clk);
        vectors++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL mid_pre_gnt: got %b expected 1", fetch_gnt); end
        tick();
        rst_n = 0; ld_req = 1; ld_we = 1;
        #1;
        vectors++; if ({fetch_rvalid, ld_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rvalid_dropped: got %b expected 00", {fetch_rvalid, ld_rvalid}); end
        vectors++; if ({fetch_gnt, ld_gnt, mem_req, mem_we} !== 4'b0000) begin errors++; $display("FAIL mid_gnt_mem: got %b expected 0000", {fetch_gnt, ld_gnt, mem_req, mem_we}); end
        vectors++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL mid_core_rst_n: got %b expected 0", core_rst_n); end
        tick();
        rst_n = 1; ld_req = 0; ld_we = 0;
        @(negedge clk);
        vectors++; if ({fetch_gnt, fetch_rvalid, core_rst_n} !== 3'b000) begin errors++; $display("FAIL mid_after_release: got %b expected 000", {fetch_gnt, fetch_rvalid, core_rst_n}); end
        idle_inputs();
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = 32'hA5A5_0000 ^ (i * 32'h0001_0203);
            ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0203);
        end
        mem_rdata = '0;
        idle_inputs();
        fetch_addr = '0; ld_addr = '0; ld_wdata = '0;
        rst_n = 0;
        test_reset();
        test_boot_load();
        test_done_fetch();
        test_starve();
        test_random_run();
        test_halt_drain();
        test_done_halt_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
